rx_tmp_buf_slab_alloc: RTL

//  Free-list allocator for the RX temporary payload buffer (NUM_SLABS slabs of 2^SLAB_BYTES_W bytes).

---
 rtl/rx_tmp_buf_slab_alloc.sv | 116 +++++++++++
 1 files changed

// File: rtl/rx_tmp_buf_slab_alloc.sv
// rtl/rx_tmp_buf_slab_alloc.sv - RX temp buffer slab free-list allocator
// Optional double-free detection enabled by defining RX_SLAB_ALLOC_CHECK_EN.
module rx_tmp_buf_slab_alloc #(
  parameter int NUM_SLABS    = 16,
  parameter int SLAB_NUM_W   = 4,
  parameter int SLAB_BYTES_W = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               alloc_slab_val,
  input  logic                               alloc_slab_rdy,
  output logic [SLAB_NUM_W-1:0]              alloc_slab_num,
  output logic [SLAB_NUM_W+SLAB_BYTES_W-1:0] alloc_slab_addr,
  input  logic                               free_val,
  output logic                               free_rdy,
  input  logic [SLAB_NUM_W-1:0]              free_slab_num,
  output logic [SLAB_NUM_W:0]                free_cnt,
  output logic                               init_done,
  output logic                               err_double_free
);

  localparam logic [SLAB_NUM_W:0]   FULL_CNT = (SLAB_NUM_W+1)'(NUM_SLABS);
  localparam logic [SLAB_NUM_W-1:0] LAST_IDX = SLAB_NUM_W'(NUM_SLABS - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state, state_nxt;
  logic [SLAB_NUM_W-1:0] entries [NUM_SLABS];
  logic [SLAB_NUM_W-1:0] rd_ptr, wr_ptr, init_cnt;
  logic                  init_wr, pop, free_fire, push, wr_en;
  logic [SLAB_NUM_W-1:0] wr_data;

  function automatic logic [SLAB_NUM_W-1:0] ptr_inc(input logic [SLAB_NUM_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    init_wr        = 1'b0;
    alloc_slab_val = 1'b0;
    free_rdy       = 1'b0;
    case (state)
      ST_INIT: begin
        init_wr = 1'b1;
        if (init_cnt == LAST_IDX) state_nxt = ST_READY;
      end
      ST_READY: begin
        alloc_slab_val = (free_cnt != '0);
        // Full list refuses frees even when a pop happens the same cycle.
        free_rdy       = (free_cnt != FULL_CNT);
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign init_done       = (state == ST_READY);
  assign alloc_slab_num  = entries[rd_ptr];
  assign alloc_slab_addr = {alloc_slab_num, {SLAB_BYTES_W{1'b0}}};
  assign pop             = alloc_slab_val & alloc_slab_rdy;
  assign free_fire       = free_val & free_rdy;

`ifdef RX_SLAB_ALLOC_CHECK_EN
  logic [NUM_SLABS-1:0] in_use;
  logic                 err_q;

  // Pre-update bitmap: freeing the slab being popped this cycle is a double free.
  assign push = free_fire & in_use[free_slab_num];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) in_use[free_slab_num] <= 1'b0;
      if (pop)  in_use[alloc_slab_num] <= 1'b1;
      if (free_fire && !in_use[free_slab_num]) err_q <= 1'b1;
    end
  end

  assign err_double_free = err_q;
`else
  assign push            = free_fire;
  assign err_double_free = 1'b0;
`endif

  assign wr_en   = init_wr | push;
  assign wr_data = init_wr ? init_cnt : free_slab_num;

  always_ff @(posedge clk) begin
    if (wr_en) entries[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      init_cnt <= '0;
      free_cnt <= '0;
    end else begin
      if (init_wr) init_cnt <= ptr_inc(init_cnt);
      if (wr_en)   wr_ptr   <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr   <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   free_cnt <= free_cnt + 1'b1;
        2'b01:   free_cnt <= free_cnt - 1'b1;
        default: free_cnt <= free_cnt;
      endcase
    end
  end

endmodule
